// File: rtl/dac_pacer_pkg.sv
// Shared types and helpers for the DAC sample pacer.
//  pair_t     : one sample pair, channel 1 in the upper half, channel 0 in the lower half
//  pace_st_t  : pacing FSM states (IDLE = no pair on the outputs, PEND = pair being consumed)
//  sat_inc    : saturating increment used by the statistics counters
package dac_pacer_pkg;

    localparam int DATA_WIDTH = 14;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d1;
        logic [DATA_WIDTH-1:0] d0;
    } pair_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pace_st_t;

    // Returns val+1, but never exceeds max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        logic [31:0] res;
        if (val >= max_val) begin
            res = max_val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dac_pacer_fifo.sv
// Single-clock FIFO of sample pairs with a registered, show-ahead read port.
// The head entry is always present on pop_data while the FIFO is non-empty;
// an entry pushed into an empty FIFO appears on pop_data the following cycle.
// Ports:
//  clk, reset  : clock and synchronous active-high reset (flushes pointers/level)
//  push, push_data : write request and pair (ignored when full)
//  pop         : advance to the next entry (ignored when empty)
//  pop_data    : current head entry
//  full, empty : status flags
//  level       : number of stored pairs, 0..2**FIFO_AW
module dac_pacer_fifo
    import dac_pacer_pkg::*;
#(
    parameter int FIFO_AW = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  pair_t            push_data,
    input  logic             pop,
    output pair_t            pop_data,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level
);

    localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    pair_t              mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    pair_t              rd_data_q, rd_data_d;
    logic               push_ok_s, pop_ok_s;

    // Pointer, level and head-register next-state logic.
    always_comb begin
        push_ok_s = push && (level_q != DEPTH);
        pop_ok_s  = pop && (level_q != {(FIFO_AW+1){1'b0}});

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // The new head is being written this very cycle only when the FIFO is
        // (or becomes) empty, so forward the write data around the array.
        if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = push_data;
        end else begin
            rd_data_d = mem[rd_ptr_d];
        end
    end

    // Storage array write port; left unreset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Control registers and registered head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= {FIFO_AW{1'b0}};
            rd_ptr_q  <= {FIFO_AW{1'b0}};
            level_q   <= {(FIFO_AW+1){1'b0}};
            rd_data_q <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign pop_data = rd_data_q;
    assign level    = level_q;
    assign full     = (level_q == DEPTH);
    assign empty    = (level_q == {(FIFO_AW+1){1'b0}});

endmodule

// File: rtl/dac_sample_pacer.sv
// Dual-channel sample buffer and rate pacer feeding the AD56x3 DAC driver.
// Buffers sample pairs in a FIFO and releases exactly one pair per programmable
// period as simultaneous srcValid0/srcValid1 beats; reports FIFO level and
// saturating underrun / late-tick counts.
// Ports:
//  clk, reset          : clock, synchronous active-high reset
//  enable, rateDiv     : pacing enable; tick every rateDiv+1 cycles
//  clrStat             : zero underrunCnt and lateCnt (wins over an increment)
//  snkValid/snkData0/snkData1/snkRdy : pair input handshake
//  srcValidN/srcDataN/srcRdyN        : per-channel output handshake to the DAC driver
//  fillLevel, underrunCnt, lateCnt   : status
// Build option: DAC_PACER_UNDERRUN_HOLD_EN -- when defined, an underrun tick
// re-presents the last output pair (0/0 if none has been sent yet).
module dac_sample_pacer #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_AW    = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  rateDiv,
    input  logic                  clrStat,
    input  logic                  snkValid,
    input  logic [DATA_WIDTH-1:0] snkData0,
    input  logic [DATA_WIDTH-1:0] snkData1,
    output logic                  snkRdy,
    output logic                  srcValid0,
    output logic [DATA_WIDTH-1:0] srcData0,
    input  logic                  srcRdy0,
    output logic                  srcValid1,
    output logic [DATA_WIDTH-1:0] srcData1,
    input  logic                  srcRdy1,
    output logic [FIFO_AW:0]      fillLevel,
    output logic [CNT_WIDTH-1:0]  underrunCnt,
    output logic [CNT_WIDTH-1:0]  lateCnt
);
    import dac_pacer_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] rate_q, rate_d;
    logic [CNT_WIDTH-1:0] underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0] late_q, late_d;
    pace_st_t             state_q, state_d;
    logic                 valid0_q, valid0_d;
    logic                 valid1_q, valid1_d;
    pair_t                out_q, out_d;

    logic                 tick_s, pop_s, push_s;
    logic                 underrun_inc_s, late_inc_s;
    logic                 fifo_full_s, fifo_empty_s;
    pair_t                push_pair_s, fifo_head_s;
    logic [FIFO_AW:0]     level_s;

    assign push_pair_s.d0 = snkData0;
    assign push_pair_s.d1 = snkData1;
    assign push_s         = snkValid && !fifo_full_s;

    dac_pacer_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_pair_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (level_s)
    );

    // Tick counter; the period register only reloads at a wrap (or while idle)
    // so a rateDiv change never truncates or stretches the running period oddly.
    always_comb begin
        if (!enable) begin
            cnt_d  = CNT_ZERO;
            rate_d = rateDiv;
            tick_s = 1'b0;
        end else if (cnt_q == rate_q) begin
            cnt_d  = CNT_ZERO;
            rate_d = rateDiv;
            tick_s = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_ONE;
            rate_d = rate_q;
            tick_s = 1'b0;
        end
    end

    // Pacing FSM: one pair per tick, both channels released together.
    always_comb begin
        state_d        = state_q;
        valid0_d       = valid0_q;
        valid1_d       = valid1_q;
        out_d          = out_q;
        pop_s          = 1'b0;
        underrun_inc_s = 1'b0;
        late_inc_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_s && !fifo_empty_s) begin
                    pop_s    = 1'b1;
                    out_d    = fifo_head_s;
                    valid0_d = 1'b1;
                    valid1_d = 1'b1;
                    state_d  = PEND;
                end else if (tick_s) begin
                    underrun_inc_s = 1'b1;
`ifdef DAC_PACER_UNDERRUN_HOLD_EN
                    valid0_d = 1'b1;
                    valid1_d = 1'b1;
                    state_d  = PEND;
`else
                    state_d  = IDLE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (valid0_q && srcRdy0) begin
                    valid0_d = 1'b0;
                end else begin
                    valid0_d = valid0_q;
                end
                if (valid1_q && srcRdy1) begin
                    valid1_d = 1'b0;
                end else begin
                    valid1_d = valid1_q;
                end
                // Leave PEND in the cycle the last outstanding channel is taken.
                if (!valid0_d && !valid1_d) begin
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
                // Any tick seen here is dropped, even one coinciding with completion.
                if (tick_s) begin
                    late_inc_s = 1'b1;
                end else begin
                    late_inc_s = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                valid0_d = 1'b0;
                valid1_d = 1'b0;
            end
        endcase
    end

    // Statistics counters: clear has priority over a coincident increment.
    always_comb begin
        if (clrStat) begin
            underrun_d = CNT_ZERO;
        end else if (underrun_inc_s) begin
            underrun_d = CNT_WIDTH'(sat_inc(32'(underrun_q), 32'(CNT_MAX)));
        end else begin
            underrun_d = underrun_q;
        end
        if (clrStat) begin
            late_d = CNT_ZERO;
        end else if (late_inc_s) begin
            late_d = CNT_WIDTH'(sat_inc(32'(late_q), 32'(CNT_MAX)));
        end else begin
            late_d = late_q;
        end
    end

    // State, output and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= CNT_ZERO;
            rate_q     <= rateDiv;
            underrun_q <= CNT_ZERO;
            late_q     <= CNT_ZERO;
            state_q    <= IDLE;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
            out_q      <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            rate_q     <= rate_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
            state_q    <= state_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
            out_q      <= out_d;
        end
    end

    assign snkRdy      = !fifo_full_s;
    assign srcValid0   = valid0_q;
    assign srcValid1   = valid1_q;
    assign srcData0    = out_q.d0;
    assign srcData1    = out_q.d1;
    assign fillLevel   = level_s;
    assign underrunCnt = underrun_q;
    assign lateCnt     = late_q;

endmodule
